// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard/flush controller
package hazard_ctrl_pkg;

    localparam logic [6:0] INST_TYPE_L = 7'b0000011;
    localparam logic       RstEnable   = 1'b0;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_LU    = 2'd1,
        CAUSE_EXT   = 2'd2,
        CAUSE_FLUSH = 2'd3
    } stall_cause_e;

    typedef struct packed {
        logic hold_pc;
        logic hold_if_id;
        logic hold_id_ex;
        logic flush_if_id;
        logic flush_id_ex;
    } pipe_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle of the hazard controller
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int NUM_HOLD_SRC = 4
) ();

    logic                    ex_jump_flag_i;
    logic [ADDR_W-1:0]       ex_jump_addr_i;
    logic [NUM_HOLD_SRC-1:0] hold_req_i;
    logic                    ex_valid_i;
    logic [6:0]              ex_opcode_i;
    logic [REG_ADDR_W-1:0]   ex_rd_addr_i;
    logic [REG_ADDR_W-1:0]   id_rs1_addr_i;
    logic [REG_ADDR_W-1:0]   id_rs2_addr_i;
    logic                    id_rs1_used_i;
    logic                    id_rs2_used_i;

    logic                    pc_jump_flag_o;
    logic [ADDR_W-1:0]       pc_jump_addr_o;
    logic                    hold_pc_o;
    logic                    hold_if_id_o;
    logic                    hold_id_ex_o;
    logic                    flush_if_id_o;
    logic                    flush_id_ex_o;
    stall_cause_e            stall_cause_o;
    logic                    timeout_err_o;

    modport master (
        output ex_jump_flag_i, ex_jump_addr_i, hold_req_i, ex_valid_i, ex_opcode_i,
               ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
        input  pc_jump_flag_o, pc_jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, stall_cause_o, timeout_err_o
    );

    modport slave (
        input  ex_jump_flag_i, ex_jump_addr_i, hold_req_i, ex_valid_i, ex_opcode_i,
               ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
        output pc_jump_flag_o, pc_jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, stall_cause_o, timeout_err_o
    );

endinterface

// File: rtl/hazard_ctrl_lu_det.sv
// rtl/hazard_ctrl_lu_det.sv - combinational load-use hazard compare between EX and ID
module hazard_ctrl_lu_det
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_valid_i,
    input  logic [6:0]            ex_opcode_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    output logic                  lu_hit_o
);

    // x0 is never a real producer, so a load targeting it cannot create a hazard
    assign lu_hit_o = ex_valid_i && (ex_opcode_i == INST_TYPE_L) && (ex_rd_addr_i != '0) &&
                      ((id_rs1_used_i && (ex_rd_addr_i == id_rs1_addr_i)) ||
                       (id_rs2_used_i && (ex_rd_addr_i == id_rs2_addr_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - jump/hold/load-use arbitration with zero-latency stage controls
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int NUM_HOLD_SRC = 4,
    parameter int LU_STALL_CYC = 1,
    parameter int FLUSH_CYC    = 1,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_LU    = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam int          LU_CW = $clog2(LU_STALL_CYC + 1);
    localparam int          FL_CW = $clog2(FLUSH_CYC + 1);
    localparam logic [31:0] TO_LIM = HOLD_TIMEOUT;

    logic [1:0]       state_q, state_d;
    logic [LU_CW-1:0] lu_cnt_q, lu_cnt_d;
    logic [FL_CW-1:0] fl_cnt_q, fl_cnt_d;
    logic [15:0]      wd_cnt_q, wd_cnt_d;
    logic             err_q;

    logic         active, jump, ext_hold, lu_hit, any_hold, wd_hit;
    pipe_ctrl_t   ctrl;
    stall_cause_e cause;

    hazard_ctrl_lu_det #(.REG_ADDR_W(REG_ADDR_W)) u_lu_det (
        .ex_valid_i    (bus.ex_valid_i),
        .ex_opcode_i   (bus.ex_opcode_i),
        .ex_rd_addr_i  (bus.ex_rd_addr_i),
        .id_rs1_addr_i (bus.id_rs1_addr_i),
        .id_rs2_addr_i (bus.id_rs2_addr_i),
        .id_rs1_used_i (bus.id_rs1_used_i),
        .id_rs2_used_i (bus.id_rs2_used_i),
        .lu_hit_o      (lu_hit)
    );

    // Outputs are combinational, so reset must gate them directly to read as zero
    assign active   = (rst_n != RstEnable);
    assign jump     = active && bus.ex_jump_flag_i;
    assign ext_hold = |bus.hold_req_i[NUM_HOLD_SRC-1:0];

    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        fl_cnt_d = fl_cnt_q;
        ctrl     = '0;
        cause    = CAUSE_NONE;
        if (jump) begin
            ctrl.flush_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
            cause            = CAUSE_FLUSH;
            lu_cnt_d         = '0;
            if (FLUSH_CYC > 1) begin
                state_d  = S_FLUSH;
                fl_cnt_d = FL_CW'(FLUSH_CYC - 1);
            end else begin
                state_d  = S_RUN;
            end
        end else if (state_q == S_FLUSH) begin
            ctrl.flush_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
            cause            = CAUSE_FLUSH;
            if (!ext_hold) begin
                if (fl_cnt_q <= FL_CW'(1)) begin
                    state_d  = S_RUN;
                    fl_cnt_d = '0;
                end else begin
                    fl_cnt_d = fl_cnt_q - FL_CW'(1);
                end
            end
        end else if (ext_hold) begin
            // Freezes any load-use countdown; a pending hit is re-evaluated afterwards
            ctrl.hold_pc    = 1'b1;
            ctrl.hold_if_id = 1'b1;
            ctrl.hold_id_ex = 1'b1;
            cause           = CAUSE_EXT;
        end else if ((state_q == S_LU) || lu_hit) begin
            ctrl.hold_pc     = 1'b1;
            ctrl.hold_if_id  = 1'b1;
            ctrl.flush_id_ex = 1'b1;
            cause            = CAUSE_LU;
            if (state_q == S_LU) begin
                if (lu_cnt_q <= LU_CW'(1)) begin
                    state_d  = S_RUN;
                    lu_cnt_d = '0;
                end else begin
                    lu_cnt_d = lu_cnt_q - LU_CW'(1);
                end
            end else if (LU_STALL_CYC > 1) begin
                state_d  = S_LU;
                lu_cnt_d = LU_CW'(LU_STALL_CYC - 1);
            end
        end
    end

    assign any_hold = active && (ctrl.hold_pc || ctrl.hold_if_id || ctrl.hold_id_ex);
    assign wd_cnt_d = !any_hold ? 16'd0 : (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : wd_cnt_q + 16'd1;
    // Error is visible in the very cycle whose hold makes the count reach the limit
    assign wd_hit   = (TO_LIM != 32'd0) && any_hold && (({16'd0, wd_cnt_q} + 32'd1) >= TO_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            state_q  <= S_RUN;
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            fl_cnt_q <= fl_cnt_d;
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_q | wd_hit;
        end
    end

    assign bus.pc_jump_flag_o = jump;
    assign bus.pc_jump_addr_o = {ADDR_W{jump}} & bus.ex_jump_addr_i;
    assign bus.hold_pc_o      = active && ctrl.hold_pc;
    assign bus.hold_if_id_o   = active && ctrl.hold_if_id;
    assign bus.hold_id_ex_o   = active && ctrl.hold_id_ex;
    assign bus.flush_if_id_o  = active && ctrl.flush_if_id;
    assign bus.flush_id_ex_o  = active && ctrl.flush_id_ex;
    assign bus.stall_cause_o  = active ? cause : CAUSE_NONE;
    assign bus.timeout_err_o  = active && (err_q || wd_hit);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - two-configuration random and directed bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump;
    logic [31:0] jaddr;
    logic [3:0]  hold_req;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd, rs1, rs2;
    logic        rs1_used, rs2_used;

    int checks = 0;
    int failures = 0;
    int n_lu, n_ext, n_fl;

    // Model state per instance: index 0 = config A, 1 = config B
    int lu_cyc[2]  = '{3, 1};
    int fl_cyc[2]  = '{2, 1};
    int to_lim[2]  = '{8, 0};
    int flush_rem[2], lu_rem[2], wd[2];
    bit err_m[2];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.ADDR_W(32), .REG_ADDR_W(5), .NUM_HOLD_SRC(4)) bus_a ();
    hazard_ctrl_if #(.ADDR_W(32), .REG_ADDR_W(5), .NUM_HOLD_SRC(4)) bus_b ();

    assign bus_a.ex_jump_flag_i = jump;
    assign bus_a.ex_jump_addr_i = jaddr;
    assign bus_a.hold_req_i     = hold_req;
    assign bus_a.ex_valid_i     = ex_valid;
    assign bus_a.ex_opcode_i    = ex_opcode;
    assign bus_a.ex_rd_addr_i   = ex_rd;
    assign bus_a.id_rs1_addr_i  = rs1;
    assign bus_a.id_rs2_addr_i  = rs2;
    assign bus_a.id_rs1_used_i  = rs1_used;
    assign bus_a.id_rs2_used_i  = rs2_used;
    assign bus_b.ex_jump_flag_i = jump;
    assign bus_b.ex_jump_addr_i = jaddr;
    assign bus_b.hold_req_i     = hold_req;
    assign bus_b.ex_valid_i     = ex_valid;
    assign bus_b.ex_opcode_i    = ex_opcode;
    assign bus_b.ex_rd_addr_i   = ex_rd;
    assign bus_b.id_rs1_addr_i  = rs1;
    assign bus_b.id_rs2_addr_i  = rs2;
    assign bus_b.id_rs1_used_i  = rs1_used;
    assign bus_b.id_rs2_used_i  = rs2_used;

    hazard_ctrl #(.ADDR_W(32), .REG_ADDR_W(5), .NUM_HOLD_SRC(4),
                  .LU_STALL_CYC(3), .FLUSH_CYC(2), .HOLD_TIMEOUT(8))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    hazard_ctrl #(.ADDR_W(32), .REG_ADDR_W(5), .NUM_HOLD_SRC(4),
                  .LU_STALL_CYC(1), .FLUSH_CYC(1), .HOLD_TIMEOUT(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    wire [8:0] obs_a = {bus_a.pc_jump_flag_o, bus_a.hold_pc_o, bus_a.hold_if_id_o, bus_a.hold_id_ex_o,
                        bus_a.flush_if_id_o, bus_a.flush_id_ex_o, bus_a.stall_cause_o, bus_a.timeout_err_o};
    wire [8:0] obs_b = {bus_b.pc_jump_flag_o, bus_b.hold_pc_o, bus_b.hold_if_id_o, bus_b.hold_id_ex_o,
                        bus_b.flush_if_id_o, bus_b.flush_id_ex_o, bus_b.stall_cause_o, bus_b.timeout_err_o};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Tracks "remaining stall/flush cycles" rather than any state encoding
    task automatic model(input int d, output logic [8:0] exp_v, output logic [31:0] exp_addr);
        bit hit, ext, pj, hpc, hif, hex, fif, fex;
        int cause, cnt;
        hit = ex_valid && (ex_opcode == 7'h03) && (ex_rd != 0) &&
              ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
        ext = (hold_req != 0);
        {pj, hpc, hif, hex, fif, fex} = '0;
        cause = 0;
        if (!rst_n) begin
            flush_rem[d] = 0; lu_rem[d] = 0; wd[d] = 0; err_m[d] = 0;
        end else begin
            if (jump) begin
                pj = 1; fif = 1; fex = 1; cause = 3;
                flush_rem[d] = fl_cyc[d] - 1;
                lu_rem[d] = 0;
            end else if (flush_rem[d] > 0) begin
                fif = 1; fex = 1; cause = 3;
                if (!ext) flush_rem[d]--;
            end else if (ext) begin
                hpc = 1; hif = 1; hex = 1; cause = 2;
            end else if (lu_rem[d] > 0 || hit) begin
                hpc = 1; hif = 1; fex = 1; cause = 1;
                if (lu_rem[d] > 0) lu_rem[d]--;
                else lu_rem[d] = lu_cyc[d] - 1;
            end
            cnt = (hpc || hif || hex) ? wd[d] + 1 : 0;
            if (cnt > 65535) cnt = 65535;
            if (to_lim[d] != 0 && cnt >= to_lim[d]) err_m[d] = 1;
            wd[d] = cnt;
        end
        exp_v    = {pj, hpc, hif, hex, fif, fex, 2'(cause), err_m[d]};
        exp_addr = pj ? jaddr : 32'd0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        jump = 0; jaddr = $urandom; hold_req = 0; ex_valid = 0; ex_opcode = 7'h33;
        ex_rd = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    endtask

    task automatic eval();
        logic [8:0]  ev;
        logic [31:0] ea;
        #1;
        model(0, ev, ea);
        check("ctrl_a", 64'(obs_a), 64'(ev));
        check("addr_a", 64'(bus_a.pc_jump_addr_o), 64'(ea));
        model(1, ev, ea);
        check("ctrl_b", 64'(obs_b), 64'(ev));
        check("addr_b", 64'(bus_b.pc_jump_addr_o), 64'(ea));
        if (bus_a.stall_cause_o == CAUSE_LU)    n_lu++;
        if (bus_a.stall_cause_o == CAUSE_EXT)   n_ext++;
        if (bus_a.stall_cause_o == CAUSE_FLUSH) n_fl++;
    endtask

    task automatic load_use_x5();
        ex_valid = 1; ex_opcode = 7'h03; ex_rd = 5; rs1 = 5; rs1_used = 1;
    endtask

    task automatic reset_pulse();
        next_cycle(); rst_n = 0; eval();
        check("reset_outputs_zero", 64'(obs_a | obs_b), 64'd0);
        next_cycle(); rst_n = 1; eval();
    endtask

    initial begin
        int hold_left;
        logic [3:0] hold_val;
        hold_left = 0;
        hold_val = 0;

        reset_pulse();

        // Load-use on rs1: B stalls once, A stalls three cycles
        n_lu = 0;
        next_cycle(); load_use_x5(); eval();
        for (int i = 0; i < 3; i++) begin next_cycle(); eval(); end
        check("t1_lu_cycles_a", 64'(n_lu), 64'd3);

        // No stall: load to x0, or rs2 match with rs2 unused
        next_cycle(); ex_valid = 1; ex_opcode = 7'h03; ex_rd = 0; rs1 = 0; rs1_used = 1; eval();
        check("t2_x0_nostall", 64'(bus_b.stall_cause_o), 64'd0);
        next_cycle(); ex_valid = 1; ex_opcode = 7'h03; ex_rd = 5; rs2 = 5; rs2_used = 0; eval();
        check("t2_rs2_unused_nostall", 64'(bus_b.hold_pc_o), 64'd0);

        // External hold in the middle of a 3-cycle load-use stall
        n_lu = 0; n_ext = 0;
        next_cycle(); load_use_x5(); eval();
        next_cycle(); hold_req = 4'b0010; eval();
        next_cycle(); hold_req = 4'b0010; eval();
        for (int i = 0; i < 3; i++) begin next_cycle(); eval(); end
        check("t3_lu_cycles", 64'(n_lu), 64'd3);
        check("t3_ext_cycles", 64'(n_ext), 64'd2);

        // Jump beats a simultaneous hold; flush stretched to two cycles
        n_fl = 0;
        next_cycle(); jump = 1; jaddr = 32'h100; hold_req = 4'b0001; eval();
        check("t4_addr", 64'(bus_a.pc_jump_addr_o), 64'h100);
        check("t4_hold_pc", 64'(bus_a.hold_pc_o), 64'd0);
        next_cycle(); eval();
        check("t4_jump_flag_gone", 64'(bus_a.pc_jump_flag_o), 64'd0);
        next_cycle(); eval();
        check("t4_flush_cycles", 64'(n_fl), 64'd2);

        // Watchdog: ten held cycles, error appears on the eighth
        reset_pulse();
        for (int i = 1; i <= 10; i++) begin
            next_cycle(); hold_req = 4'b1000; eval();
            if (i == 7) check("t5_err_before", 64'(bus_a.timeout_err_o), 64'd0);
            if (i == 8) check("t5_err_rise", 64'(bus_a.timeout_err_o), 64'd1);
        end
        next_cycle(); eval();
        next_cycle(); eval();
        check("t5_err_sticky", 64'(bus_a.timeout_err_o), 64'd1);
        check("t5_err_disabled_b", 64'(bus_b.timeout_err_o), 64'd0);
        reset_pulse();
        check("t5_err_cleared", 64'(bus_a.timeout_err_o), 64'd0);

        // Reset during a load-use stall leaves no residue
        next_cycle(); load_use_x5(); eval();
        next_cycle(); rst_n = 0; eval();
        check("t6_reset_mid_stall", 64'(obs_a), 64'd0);
        next_cycle(); rst_n = 1; eval();
        check("t6_no_residual", 64'(bus_a.stall_cause_o), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst_n = ($urandom_range(0, 199) != 0);
            jump = ($urandom_range(0, 11) == 0);
            if (hold_left == 0 && $urandom_range(0, 5) == 0) begin
                hold_left = $urandom_range(1, 12);
                hold_val  = 4'($urandom_range(1, 15));
            end
            if (hold_left > 0) begin
                hold_req = hold_val;
                hold_left--;
            end
            ex_valid  = ($urandom_range(0, 3) != 0);
            ex_opcode = $urandom_range(0, 1) ? 7'h03 : 7'h13;
            ex_rd     = 5'($urandom_range(0, 3));
            rs1       = 5'($urandom_range(0, 3));
            rs2       = 5'($urandom_range(0, 3));
            rs1_used  = 1'($urandom_range(0, 1));
            rs2_used  = 1'($urandom_range(0, 1));
            eval();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
